pipe_flow_ctrl: RTL

//  Central flow controller for the 5-stage pipeline registers (F/D/E/M/W).

---
 rtl/pipe_flow_ctrl.sv | 77 +++++++
 1 files changed

// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: central flow controller for the five pipeline registers.
// Merges RAW stalls, HI/LO busy stalls and CP0 requests into enable/clear
// strobes. It also owns the mult/div busy countdown and a saturating
// stall-cycle counter.
module pipe_flow_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard_stall,
  input  logic        d_is_md,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  input  logic        int_req,
  output logic        f_en,
  output logic        d_en,
  output logic        e_clr,
  output logic        req,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  logic [CNT_W-1:0] busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             md_stall;
  logic             stall;
  logic             md_load;

  // Zero-latency strobes; a flush request overrides any stall so the PC can load the handler
  always_comb begin
    req      = int_req & ~reset;
    md_stall = d_is_md & ((busy_q != '0) | e_md_start);
    stall    = (hazard_stall | md_stall) & ~req;
    f_en     = ~stall;
    d_en     = ~stall;
    e_clr    = stall | req;
  end

  // Next-state for busy countdown, completion pulse and stall counter
  always_comb begin
    md_load     = e_md_start & ~req;
    busy_d      = busy_q;
    done_d      = 1'b0;
    stall_cnt_d = stall_cnt_q;
    if (md_load) begin
      busy_d = e_md_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (busy_q != '0) begin
      busy_d = busy_q - 1'b1;
      done_d = (busy_q == CNT_W'(1));
    end
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Registered state with synchronous reset; a running count survives a flush
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      done_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy   = (busy_q != '0);
  assign md_done   = done_q;
  assign stall_cnt = stall_cnt_q;

endmodule
